data_mem_hs: RTL and testbench
==============================

Name: data_mem_hs

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised RAM mapped at a configurable byte base address, with per-byte write strobes and address range/alignment checking.
- Request/response valid-ready handshake with programmable response latency.
- A post-reset sequential clear engine zeroes the array. Sits between the CPU memory stage (or a bus adapter) and data storage.

Parameters:
- DW, 32, data word width in bits; must be a multiple of 8, at least 8.
- DEPTH, 64, number of words; power of two.
- BASE, 1024, byte address of word 0.
- LATENCY, 1, cycles from request acceptance to resp_valid; range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  DW  write data.
- req_be  input  DW/8  byte write enables; bit i covers data bits 8i+7:8i.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  DW  read data; 0 for writes and errors.
- resp_err  output  1  request was out of range or misaligned.
- init_done  output  1  array clear complete.

Behaviour:
- Reset rst is asynchronous and active-high; clock clk.
- On rst:
  - State goes to INIT and the clear pointer goes to 0.
  - Outputs reset as: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0.
- States:
  - INIT: writes 0 to word[ptr] each cycle. After ptr = DEPTH-1 it goes to IDLE and sets init_done=1 (held until the next rst). INIT lasts exactly DEPTH cycles.
  - IDLE: req_ready=1. A request is accepted when req_valid and req_ready are both high at a rising edge. On acceptance:
    - If LATENCY=1, go to RESP.
    - Otherwise load the counter with LATENCY-1 and go to WAIT.
  - WAIT: req_ready=0. The counter decrements each cycle; at count 1 go to RESP.
  - RESP: resp_valid=1 and req_ready=0. The state holds until resp_ready=1 at an edge, then returns to IDLE. The next request may be accepted one cycle later; there are no back-to-back accepts.
- Resulting timing: resp_valid first rises exactly LATENCY cycles after the accept edge. resp_rdata and resp_err stay stable while resp_valid=1.
- Address decode, all done at the accept edge:
  - Index = (req_addr - BASE) >> log2(DW/8).
  - Error if req_addr < BASE, or req_addr >= BASE + DEPTH*(DW/8), or req_addr is not aligned to DW/8. Subtraction is 32-bit unsigned; the below-BASE check must not rely on wrap-around.
- Write semantics:
  - A write commits at the accept edge, updating only bytes whose req_be bit is 1.
  - req_be of all zeros is legal: no change, normal response.
  - An error suppresses the write entirely.
  - The response carries resp_rdata=0, with resp_err per the decode.
- Read semantics:
  - The word is captured at the accept edge into the response register.
  - An error forces resp_rdata=0 and resp_err=1.
  - A later write cannot alter a captured read; none can occur before the response is consumed.
- Requests presented during INIT, WAIT or RESP are not accepted. req_valid may stay high; the requester must hold its fields stable until accepted.
- resp_ready while resp_valid=0 is ignored.
- Reset mid-operation (WAIT or RESP): the pending response is discarded, its write is kept only if it had already committed, and the array is re-cleared.
- Memory is not readable or writable other than through the handshake. No combinational path from req_* to resp_*.

Test Plan:
- Reset, then hold req_valid=0 -> init_done rises after exactly 64 cycles; a read of 0x400 returns 0x00000000 with resp_err=0.
- LATENCY=1: write 0xDEADBEEF to 0x404 with be=4'hF, then read 0x404 -> resp_valid exactly 1 cycle after each accept; rdata=0xDEADBEEF.
- Byte strobes: write 0x11223344 be=4'b0101 over 0xDEADBEEF at 0x404 -> read returns 0xDE22BE44.
- Errors: read 0x3FC, read 0x500 and write 0x402 -> each gives resp_err=1 and rdata=0; a subsequent read of 0x400 is unchanged.
- LATENCY=4 with resp_ready held 0 for 3 cycles -> resp_valid rises 4 cycles after accept, holds with stable data, drops the cycle after resp_ready=1; req_ready=0 throughout.
- Assert rst during WAIT -> resp_valid never rises, init_done drops, a full 64-cycle re-clear runs, and the earlier data reads back as 0.

Source files
------------

// File: rtl/data_mem_hs_if.sv
// Request/response handshake bundle between a requester (CPU memory stage or
// bus adapter) and the data_mem_hs storage block.
interface data_mem_hs_if #(
    parameter int DW = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_hs.sv
// Word-organised data RAM behind a valid/ready request/response handshake,
// with byte strobes, range/alignment checking and a post-reset clear engine.
module data_mem_hs #(
    parameter int          DW      = 32,
    parameter int          DEPTH   = 64,
    parameter logic [31:0] BASE    = 32'd1024,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    data_mem_hs_if.slave bus,
    output logic        init_done
);

    localparam int BPW = DW / 8;
    localparam int OFF = (BPW > 1) ? $clog2(BPW) : 0;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [32:0] SPAN       = 33'(DEPTH * BPW);
    localparam logic [31:0] ALIGN_MASK = 32'(BPW - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [3:0]  WAIT_LOAD  = 4'(LATENCY - 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          init_done_q, init_done_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [DW-1:0] mem_wdata;

    logic [31:0]   addr_off;
    logic [AW-1:0] req_idx;
    logic          addr_err;
    logic          accept;
    logic [DW-1:0] cur_word;
    logic [DW-1:0] merged_word;

    // Below-BASE is tested directly so the offset compare never sees a wrapped value.
    always_comb begin
        addr_off = bus.req_addr - BASE;
        req_idx  = AW'(addr_off >> OFF);
        addr_err = (bus.req_addr < BASE)
                 || ({1'b0, addr_off} >= SPAN)
                 || ((bus.req_addr & ALIGN_MASK) != 32'd0);
    end

    always_comb begin
        cur_word    = mem_q[req_idx];
        merged_word = cur_word;
        for (int b = 0; b < BPW; b++) begin
            if (bus.req_be[b]) begin
                merged_word[8*b +: 8] = bus.req_wdata[8*b +: 8];
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;
        mem_widx     = ptr_q;
        mem_wdata    = '0;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_widx  = ptr_q;
                mem_wdata = '0;
                if (ptr_q == LAST_IDX) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    resp_err_d   = addr_err;
                    resp_rdata_d = (!bus.req_write && !addr_err) ? cur_word : '0;
                    if (bus.req_write && !addr_err) begin
                        mem_we    = 1'b1;
                        mem_widx  = req_idx;
                        mem_wdata = merged_word;
                    end
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Handshake outputs are registered copies of the next state.
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            init_done_q  <= init_done_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // NOTE: the array has no reset; the clear engine zeroes it so it can map to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign init_done      = init_done_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: one instance at LATENCY=1, one at LATENCY=4.
module tb_data_mem_hs;

    logic clk;
    logic rst;
    logic init_done1;
    logic init_done4;

    int vectors     = 0;
    int miscompares = 0;

    data_mem_hs_if #(.DW(32)) b1 ();
    data_mem_hs_if #(.DW(32)) b4 ();

    data_mem_hs #(.DW(32), .DEPTH(64), .BASE(32'd1024), .LATENCY(1)) u1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b1),
        .init_done (init_done1)
    );

    data_mem_hs #(.DW(32), .DEPTH(64), .BASE(32'd1024), .LATENCY(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b4),
        .init_done (init_done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (sel == 1) begin
            b1.req_valid = v; b1.req_write = w; b1.req_addr = a; b1.req_wdata = d; b1.req_be = be;
        end else begin
            b4.req_valid = v; b4.req_write = w; b4.req_addr = a; b4.req_wdata = d; b4.req_be = be;
        end
    endtask

    task automatic set_rready(input int sel, input logic r);
        if (sel == 1) b1.resp_ready = r;
        else          b4.resp_ready = r;
    endtask

    function automatic logic rq(input int sel);
        return (sel == 1) ? b1.req_ready : b4.req_ready;
    endfunction

    function automatic logic rv(input int sel);
        return (sel == 1) ? b1.resp_valid : b4.resp_valid;
    endfunction

    function automatic logic [31:0] rd(input int sel);
        return (sel == 1) ? b1.resp_rdata : b4.resp_rdata;
    endfunction

    function automatic logic re(input int sel);
        return (sel == 1) ? b1.resp_err : b4.resp_err;
    endfunction

    task automatic wait_accept(input int sel);
        int n = 0;
        while (!rq(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $error("FAIL accept_timeout: observed req_ready=0 expected req_ready=1");
        end
        @(posedge clk);
        #1 set_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Full transaction; lat = negedges after the accept edge until resp_valid is seen.
    task automatic xact(input int sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err, output int lat);
        set_req(sel, 1'b1, w, a, d, be);
        wait_accept(sel);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv(sel) && lat < 40);
        rdata = rd(sel);
        err   = re(sel);
        set_rready(sel, 1'b1);
        @(posedge clk);
        #1 set_rready(sel, 1'b0);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n;
        logic        seen;

        rst = 1'b1;
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(4, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_rready(1, 1'b0);
        set_rready(4, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_init_done", {31'd0, init_done1}, 32'd0);
        check("rst_req_ready", {31'd0, b1.req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, b1.resp_valid}, 32'd0);
        check("rst_resp_rdata", b1.resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, b1.resp_err}, 32'd0);

        // Clear engine: init_done after exactly DEPTH edges.
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!init_done1 && n < 200);
        check("init_cycles", n, 32'd64);
        check("init_done4", {31'd0, init_done4}, 32'd1);

        xact(1, 1'b0, 32'h400, 32'd0, 4'h0, rdata, err, lat);
        check("rd400_data", rdata, 32'h0);
        check("rd400_err", {31'd0, err}, 32'd0);

        xact(1, 1'b1, 32'h404, 32'hDEADBEEF, 4'hF, rdata, err, lat);
        check("wr404_lat", lat, 32'd1);
        check("wr404_rdata", rdata, 32'h0);
        check("wr404_err", {31'd0, err}, 32'd0);
        xact(1, 1'b0, 32'h404, 32'd0, 4'h0, rdata, err, lat);
        check("rd404_lat", lat, 32'd1);
        check("rd404_data", rdata, 32'hDEADBEEF);

        xact(1, 1'b1, 32'h404, 32'h11223344, 4'b0101, rdata, err, lat);
        xact(1, 1'b0, 32'h404, 32'd0, 4'h0, rdata, err, lat);
        check("strobe_data", rdata, 32'hDE22BE44);

        xact(1, 1'b1, 32'h404, 32'hFFFFFFFF, 4'h0, rdata, err, lat);
        check("be0_err", {31'd0, err}, 32'd0);
        xact(1, 1'b0, 32'h404, 32'd0, 4'h0, rdata, err, lat);
        check("be0_data", rdata, 32'hDE22BE44);

        xact(1, 1'b0, 32'h3FC, 32'd0, 4'h0, rdata, err, lat);
        check("rd3fc_err", {31'd0, err}, 32'd1);
        check("rd3fc_data", rdata, 32'h0);
        xact(1, 1'b0, 32'h500, 32'd0, 4'h0, rdata, err, lat);
        check("rd500_err", {31'd0, err}, 32'd1);
        check("rd500_data", rdata, 32'h0);
        xact(1, 1'b1, 32'h402, 32'hCAFEF00D, 4'hF, rdata, err, lat);
        check("wr402_err", {31'd0, err}, 32'd1);
        check("wr402_rdata", rdata, 32'h0);
        xact(1, 1'b0, 32'h400, 32'd0, 4'h0, rdata, err, lat);
        check("rd400_after_err", rdata, 32'h0);
        check("rd400_after_err_e", {31'd0, err}, 32'd0);

        xact(1, 1'b1, 32'h4FC, 32'h0BADCAFE, 4'hF, rdata, err, lat);
        xact(1, 1'b0, 32'h4FC, 32'd0, 4'h0, rdata, err, lat);
        check("rd4fc_data", rdata, 32'h0BADCAFE);
        check("rd4fc_err", {31'd0, err}, 32'd0);

        // LATENCY=4 instance, with a stalled consumer.
        xact(4, 1'b1, 32'h408, 32'hAABBCCDD, 4'hF, rdata, err, lat);
        check("l4_wr_lat", lat, 32'd4);
        set_req(4, 1'b1, 1'b0, 32'h408, 32'd0, 4'h0);
        wait_accept(4);
        n = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (b4.req_ready) seen = 1'b1;
        end while (!b4.resp_valid && n < 40);
        check("l4_rd_lat", n, 32'd4);
        check("l4_wait_ready", {31'd0, seen}, 32'd0);
        check("l4_rd_data", b4.resp_rdata, 32'hAABBCCDD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("l4_hold_valid", {31'd0, b4.resp_valid}, 32'd1);
            check("l4_hold_data", b4.resp_rdata, 32'hAABBCCDD);
            check("l4_hold_ready", {31'd0, b4.req_ready}, 32'd0);
        end
        set_rready(4, 1'b1);
        @(posedge clk);
        #1 set_rready(4, 1'b0);
        @(negedge clk);
        check("l4_drop_valid", {31'd0, b4.resp_valid}, 32'd0);
        check("l4_idle_ready", {31'd0, b4.req_ready}, 32'd1);

        // Reset while the LATENCY=4 instance is in WAIT.
        set_req(4, 1'b1, 1'b0, 32'h408, 32'd0, 4'h0);
        wait_accept(4);
        @(negedge clk);
        check("mid_wait_valid", {31'd0, b4.resp_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_init_done", {31'd0, init_done4}, 32'd0);
        check("mid_rst_valid", {31'd0, b4.resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        seen = 1'b0;
        do begin
            @(posedge clk);
            #1 n++;
            if (b4.resp_valid) seen = 1'b1;
        end while (!init_done4 && n < 200);
        check("reinit_cycles", n, 32'd64);
        check("reinit_no_resp", {31'd0, seen}, 32'd0);
        xact(4, 1'b0, 32'h408, 32'd0, 4'h0, rdata, err, lat);
        check("reinit_rd408", rdata, 32'h0);
        xact(1, 1'b0, 32'h404, 32'd0, 4'h0, rdata, err, lat);
        check("reinit_rd404", rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
